// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and constants for the round-robin selector arbiter
package mux_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  // Reset value of the round-robin pointer so that index 0 is searched first
  localparam logic [IDX_W-1:0] LAST_RST = 2'd3;

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational round-robin search over four requests
// Searches last+1 .. last+4 (mod 4), optionally skipping one index.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  input  logic             exclude_en,
  input  logic [IDX_W-1:0] exclude_idx,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = last + IDX_W'(k);
      if (!found && req[cand] && !(exclude_en && (cand == exclude_idx))) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter driving a 4:1 bit selector
// Optional forced handover after HOLD_CYCLES under `MUX_ARB_TIMEOUT_EN.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] I,
  output logic [N_REQ-1:0] grant,
  output logic             A,
  output logic             B,
  output logic             valid,
  output logic             Y
);

  if (HOLD_CYCLES < 2 || HOLD_CYCLES > 255) begin : g_hold_range
    $error("mux_rr_arbiter: HOLD_CYCLES must be in 2..255");
  end

  arb_state_t       state;
  arb_state_t       state_next;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] sel_next;
  logic             valid_next;
  logic             new_grant;
  logic             owner_req;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             timeout;

  assign sel       = {A, B};
  assign owner_req = req[sel];

  // In GRANT the owner is excluded so a timeout can never re-pick itself
  rr_pick4 u_pick (
    .req         (req),
    .last        (last),
    .exclude_en  (state == GRANT),
    .exclude_idx (sel),
    .found       (pick_found),
    .idx         (pick_idx)
  );

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_MAX = 8'(HOLD_CYCLES - 1);
  logic [7:0] hold_cnt;
  assign timeout = (hold_cnt == HOLD_MAX);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next = state;
    sel_next   = sel;
    valid_next = 1'b0;
    new_grant  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_next = GRANT;
          sel_next   = pick_idx;
          valid_next = 1'b1;
          new_grant  = 1'b1;
        end
      end
      GRANT: begin
        if (owner_req && !(timeout && pick_found)) begin
          valid_next = 1'b1;
        end else if (pick_found) begin
          sel_next   = pick_idx;
          valid_next = 1'b1;
          new_grant  = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A/B follow sel_next, which only moves on a new grant, so they hold in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= LAST_RST;
      grant <= '0;
      A     <= 1'b0;
      B     <= 1'b0;
      valid <= 1'b0;
      Y     <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      hold_cnt <= '0;
`endif
    end else begin
      state  <= state_next;
      valid  <= valid_next;
      grant  <= valid_next ? (N_REQ'(1) << sel_next) : '0;
      {A, B} <= sel_next;
      Y      <= valid_next & I[sel_next];
      if (new_grant) begin
        last <= sel_next;
      end
`ifdef MUX_ARB_TIMEOUT_EN
      if (new_grant) begin
        hold_cnt <= '0;
      end else if (valid_next && !timeout) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] I;
  logic [3:0] grant;
  logic       A, B, valid, Y;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .I     (I),
    .grant (grant),
    .A     (A),
    .B     (B),
    .valid (valid),
    .Y     (Y)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] grant;
    logic [1:0] ab;
    logic       valid;
    logic       y;
  } vec_t;

  vec_t vecs[14];

  // reference model state: owner -1 means idle, held counts cycles owned
  int         m_owner, m_last, m_held;
  logic [1:0] m_ab;
  logic       m_y;

  function automatic int pick(int lst, logic [3:0] r, int excl);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (lst + k) % 4;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_held  = 0;
    m_ab    = 2'b00;
    m_y     = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] d);
    int p;
    if (m_owner < 0) begin
      p = pick(m_last, r, -1);
      if (p >= 0) begin m_owner = p; m_last = p; m_held = 1; end
    end else if (!r[m_owner]) begin
      p = pick(m_last, r, m_owner);
      m_owner = p;
      if (p >= 0) begin m_last = p; m_held = 1; end
    end else begin
      p = pick(m_last, r, m_owner);
`ifdef MUX_ARB_TIMEOUT_EN
      if (m_held >= HOLD && p >= 0) begin m_owner = p; m_last = p; m_held = 1; end
      else m_held++;
`else
      m_held++;
`endif
    end
    if (m_owner >= 0) m_ab = m_owner[1:0];
    m_y = (m_owner >= 0) ? d[m_owner] : 1'b0;
  endtask

  function automatic logic [7:0] model_out();
    logic [3:0] g;
    g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    return {g, m_ab, (m_owner >= 0), m_y};
  endfunction

  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = {grant, A, B, valid, Y};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: {grant,A,B,valid,Y} got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    I     = 4'b0000;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    vecs[0]  = '{4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0};
    vecs[1]  = '{4'b0100, 4'b0100, 4'b0100, 2'b10, 1'b1, 1'b1};
    vecs[2]  = '{4'b0000, 4'b0100, 4'b0000, 2'b10, 1'b0, 1'b0};
    vecs[3]  = '{4'b1111, 4'b1010, 4'b1000, 2'b11, 1'b1, 1'b1};
    vecs[4]  = '{4'b0111, 4'b1010, 4'b0001, 2'b00, 1'b1, 1'b0};
    vecs[5]  = '{4'b1110, 4'b1010, 4'b0010, 2'b01, 1'b1, 1'b1};
    vecs[6]  = '{4'b1101, 4'b1010, 4'b0100, 2'b10, 1'b1, 1'b0};
    vecs[7]  = '{4'b1011, 4'b1010, 4'b1000, 2'b11, 1'b1, 1'b1};
    vecs[8]  = '{4'b0111, 4'b0101, 4'b0001, 2'b00, 1'b1, 1'b1};
    vecs[9]  = '{4'b1010, 4'b0101, 4'b0010, 2'b01, 1'b1, 1'b0};
    vecs[10] = '{4'b1010, 4'b0101, 4'b0010, 2'b01, 1'b1, 1'b0};
    vecs[11] = '{4'b1000, 4'b0000, 4'b1000, 2'b11, 1'b1, 1'b0};
    vecs[12] = '{4'b1000, 4'b1000, 4'b1000, 2'b11, 1'b1, 1'b1};
    vecs[13] = '{4'b0000, 4'b1000, 4'b0000, 2'b11, 1'b0, 1'b0};

    // reset values, checked while held and for 5 idle cycles after release
    rst_n = 1'b0;
    req   = 4'b0000;
    I     = 4'b1111;
    #2 check("reset_hold", 8'b0000_00_0_0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1 check("reset_idle", 8'b0000_00_0_0);
    end

    // table: single requester, fairness rotation, direct handover
    do_reset();
    for (int v = 0; v < 14; v++) begin
      req = vecs[v].req;
      I   = vecs[v].din;
      @(posedge clk);
      #1 check($sformatf("vec%0d", v),
               {vecs[v].grant, vecs[v].ab, vecs[v].valid, vecs[v].y});
    end

    // two requesters held: alternate every HOLD cycles with timeout, else owner 0 forever
    do_reset();
    req = 4'b0011;
    I   = 4'b0010;
    for (int c = 0; c < 16; c++) begin
      int o;
`ifdef MUX_ARB_TIMEOUT_EN
      o = (c / HOLD) % 2;
`else
      o = 0;
`endif
      @(posedge clk);
      #1 check($sformatf("hold_c%0d", c), {4'(1 << o), 2'(o), 1'b1, (o == 1)});
    end

    // asynchronous reset mid-grant, then first pick restarts at index 0
    do_reset();
    req = 4'b1000;
    I   = 4'b1000;
    @(posedge clk);
    #1 check("async_pre", 8'b1000_11_1_1);
    #2 rst_n = 1'b0;
    #1 check("async_clear", 8'b0000_00_0_0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    req = 4'b1001;
    I   = 4'b0001;
    @(posedge clk);
    #1 check("async_after", 8'b0001_00_1_1);

    // randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
      end
      I = 4'($urandom);
      @(posedge clk);
      model_step(req, I);
      #1 check("rand", model_out());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
